// File: rtl/spi_clk_fb_engine.sv
// Feedback SPI clock generator: after a start, idles for a programmable number of
// half periods, then emits 2*bits clock toggles with lead/trail edge strobes.
module spi_clk_fb_engine #(
  parameter int SCALE_WIDTH       = 8,
  parameter int SPI_CLK_DELAY_MAX = 7,
  parameter int FRAME_BITS_MAX    = 64,
  localparam int DELAY_W = $clog2(SPI_CLK_DELAY_MAX + 1),
  localparam int BITS_W  = $clog2(FRAME_BITS_MAX + 1),
  localparam int EDGE_W  = $clog2(2 * FRAME_BITS_MAX + 1)
) (
  input  logic                   sys_clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic [SCALE_WIDTH-1:0] cfg_scale,
  input  logic [DELAY_W-1:0]     cfg_delay,
  input  logic [BITS_W-1:0]      cfg_bits,
  input  logic                   cfg_cpol,
  output logic                   busy,
  output logic                   spi_clk_fb,
  output logic                   lead_edge,
  output logic                   trail_edge,
  output logic                   done,
  output logic                   cfg_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [SCALE_WIDTH-1:0] half_cnt, half_cnt_nxt;
  logic [DELAY_W-1:0]     delay_cnt, delay_cnt_nxt;
  logic [EDGE_W-1:0]      edge_cnt, edge_cnt_nxt;

  logic [SCALE_WIDTH-1:0] scale_q, scale_nxt;
  logic [DELAY_W-1:0]     delay_q, delay_nxt;
  logic [BITS_W-1:0]      bits_q, bits_nxt;
  logic                   cpol_q, cpol_nxt;

  logic busy_nxt, clk_nxt, lead_nxt, trail_nxt, done_nxt, err_nxt;

  logic              cfg_legal;
  logic              half_wrap;
  logic              delay_last;
  logic [EDGE_W-1:0] edge_target;
  logic [EDGE_W-1:0] edge_inc;

  // Integer compares keep the range checks meaningful for any parameter choice.
  assign cfg_legal = (cfg_scale != '0) && (cfg_bits != '0) &&
                     (int'(cfg_bits) <= FRAME_BITS_MAX) &&
                     (int'(cfg_delay) <= SPI_CLK_DELAY_MAX);

  assign half_wrap   = (half_cnt == scale_q - SCALE_WIDTH'(1));
  assign delay_last  = (delay_cnt == delay_q - DELAY_W'(1));
  assign edge_target = EDGE_W'({bits_q, 1'b0});
  assign edge_inc    = edge_cnt + EDGE_W'(1);

  always_comb begin
    state_nxt     = state;
    half_cnt_nxt  = half_cnt;
    delay_cnt_nxt = delay_cnt;
    edge_cnt_nxt  = edge_cnt;
    scale_nxt     = scale_q;
    delay_nxt     = delay_q;
    bits_nxt      = bits_q;
    cpol_nxt      = cpol_q;
    busy_nxt      = busy;
    clk_nxt       = spi_clk_fb;
    lead_nxt      = 1'b0;
    trail_nxt     = 1'b0;
    done_nxt      = 1'b0;
    err_nxt       = 1'b0;

    case (state)
      IDLE: begin
        clk_nxt       = cfg_cpol;
        busy_nxt      = 1'b0;
        half_cnt_nxt  = '0;
        delay_cnt_nxt = '0;
        edge_cnt_nxt  = '0;
        if (start) begin
          if (cfg_legal) begin
            scale_nxt = cfg_scale;
            delay_nxt = cfg_delay;
            bits_nxt  = cfg_bits;
            cpol_nxt  = cfg_cpol;
            busy_nxt  = 1'b1;
            state_nxt = (cfg_delay == '0) ? RUN : DELAY;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end

      DELAY: begin
        if (abort) begin
          state_nxt     = IDLE;
          busy_nxt      = 1'b0;
          clk_nxt       = cpol_q;
          half_cnt_nxt  = '0;
          delay_cnt_nxt = '0;
          edge_cnt_nxt  = '0;
        end else begin
          half_cnt_nxt = half_wrap ? '0 : half_cnt + SCALE_WIDTH'(1);
          if (half_wrap) begin
            if (delay_last) begin
              state_nxt     = RUN;
              delay_cnt_nxt = '0;
            end else begin
              delay_cnt_nxt = delay_cnt + DELAY_W'(1);
            end
          end
        end
      end

      RUN: begin
        if (abort) begin
          state_nxt     = IDLE;
          busy_nxt      = 1'b0;
          clk_nxt       = cpol_q;
          half_cnt_nxt  = '0;
          delay_cnt_nxt = '0;
          edge_cnt_nxt  = '0;
        end else begin
          half_cnt_nxt = half_wrap ? '0 : half_cnt + SCALE_WIDTH'(1);
          if (half_wrap) begin
            clk_nxt      = ~spi_clk_fb;
            edge_cnt_nxt = edge_inc;
            if (~spi_clk_fb == cpol_q) begin
              trail_nxt = 1'b1;
            end else begin
              lead_nxt = 1'b1;
            end
            // The last toggle lands back on cpol; the engine is free again that same cycle.
            if (edge_inc == edge_target) begin
              done_nxt     = 1'b1;
              busy_nxt     = 1'b0;
              state_nxt    = IDLE;
              edge_cnt_nxt = '0;
              half_cnt_nxt = '0;
            end
          end
        end
      end

      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      half_cnt   <= '0;
      delay_cnt  <= '0;
      edge_cnt   <= '0;
      scale_q    <= '0;
      delay_q    <= '0;
      bits_q     <= '0;
      cpol_q     <= 1'b0;
      busy       <= 1'b0;
      spi_clk_fb <= 1'b0;
      lead_edge  <= 1'b0;
      trail_edge <= 1'b0;
      done       <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      state      <= state_nxt;
      half_cnt   <= half_cnt_nxt;
      delay_cnt  <= delay_cnt_nxt;
      edge_cnt   <= edge_cnt_nxt;
      scale_q    <= scale_nxt;
      delay_q    <= delay_nxt;
      bits_q     <= bits_nxt;
      cpol_q     <= cpol_nxt;
      busy       <= busy_nxt;
      spi_clk_fb <= clk_nxt;
      lead_edge  <= lead_nxt;
      trail_edge <= trail_nxt;
      done       <= done_nxt;
      cfg_err    <= err_nxt;
    end
  end

endmodule

// File: tb/tb_spi_clk_fb_engine.sv
// Bench for spi_clk_fb_engine: closed-form frame model checked every cycle,
// plus literal cycle expectations for the reference scenarios.
module tb_spi_clk_fb_engine;

  localparam int SW   = 8;
  localparam int DMAX = 7;
  localparam int BMAX = 64;
  localparam int DW   = $clog2(DMAX + 1);
  localparam int BW   = $clog2(BMAX + 1);

  logic          sys_clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [SW-1:0] cfg_scale = 8'd2;
  logic [DW-1:0] cfg_delay = 3'd1;
  logic [BW-1:0] cfg_bits = 7'd4;
  logic          cfg_cpol = 1'b0;
  logic busy, spi_clk_fb, lead_edge, trail_edge, done, cfg_err;

  spi_clk_fb_engine #(
    .SCALE_WIDTH(SW),
    .SPI_CLK_DELAY_MAX(DMAX),
    .FRAME_BITS_MAX(BMAX)
  ) dut (
    .sys_clk(sys_clk),
    .reset(reset),
    .start(start),
    .abort(abort),
    .cfg_scale(cfg_scale),
    .cfg_delay(cfg_delay),
    .cfg_bits(cfg_bits),
    .cfg_cpol(cfg_cpol),
    .busy(busy),
    .spi_clk_fb(spi_clk_fb),
    .lead_edge(lead_edge),
    .trail_edge(trail_edge),
    .done(done),
    .cfg_err(cfg_err)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  int total = 0;
  int bad = 0;

  // Model: an active frame is described only by its start cycle and latched settings.
  bit m_active = 1'b0;
  int m_t, m_sc, m_dl, m_bt;
  bit m_cp;
  bit e_busy = 0, e_clk = 0, e_lead = 0, e_trail = 0, e_done = 0, e_err = 0;

  task automatic model_step(input int n);
    int m;
    int k;
    e_lead  = 1'b0;
    e_trail = 1'b0;
    e_done  = 1'b0;
    e_err   = 1'b0;
    if (reset) begin
      m_active = 1'b0;
      e_busy   = 1'b0;
      e_clk    = 1'b0;
    end else if (!m_active) begin
      e_clk  = cfg_cpol;
      e_busy = 1'b0;
      if (start) begin
        if (int'(cfg_scale) != 0 && int'(cfg_bits) != 0 &&
            int'(cfg_bits) <= BMAX && int'(cfg_delay) <= DMAX) begin
          m_active = 1'b1;
          m_t      = n - 1;
          m_sc     = int'(cfg_scale);
          m_dl     = int'(cfg_delay);
          m_bt     = int'(cfg_bits);
          m_cp     = cfg_cpol;
          e_busy   = 1'b1;
        end else begin
          e_err = 1'b1;
        end
      end
    end else if (abort) begin
      m_active = 1'b0;
      e_clk    = m_cp;
      e_busy   = 1'b0;
    end else begin
      m = n - m_t - 1;
      k = m / m_sc - m_dl;
      if (k < 0) k = 0;
      e_clk = m_cp ^ (k % 2 == 1);
      if (k >= 1 && m % m_sc == 0) begin
        if (k % 2 == 1) e_lead = 1'b1;
        else            e_trail = 1'b1;
      end
      if (k == 2 * m_bt) begin
        e_done   = 1'b1;
        e_busy   = 1'b0;
        m_active = 1'b0;
      end else begin
        e_busy = 1'b1;
      end
    end
  endtask

  initial begin
    logic [5:0] act;
    logic [5:0] exp;
    forever begin
      @(posedge sys_clk);
      model_step(cyc + 1);
      cyc++;
      #1;
      act = {busy, spi_clk_fb, lead_edge, trail_edge, done, cfg_err};
      exp = {e_busy, e_clk, e_lead, e_trail, e_done, e_err};
      total++;
      if (act !== exp) begin
        bad++;
        $display("[TB] FAIL model cycle %0d: got %b want %b (busy,clk,lead,trail,done,err)",
                 cyc, act, exp);
      end
    end
  end

  task automatic check_output(input string name, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("[TB] FAIL %s: got %0d want %0d", name, act, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic at_cycle(input int c);
    int guard = 0;
    while (cyc < c && guard < 100000) begin
      @(negedge sys_clk);
      guard++;
    end
  endtask

  task automatic apply_stimulus(input int sc, input int dl, input int bt, input bit cp);
    cfg_scale = SW'(sc);
    cfg_delay = DW'(dl);
    cfg_bits  = BW'(bt);
    cfg_cpol  = cp;
  endtask

  task automatic fire(output int t);
    start = 1'b1;
    t = cyc;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int when, output int edges);
    when  = -1;
    edges = 0;
    for (int i = 0; i < limit; i++) begin
      if (lead_edge || trail_edge) edges++;
      if (done) begin
        when = cyc;
        break;
      end
      tick(1);
    end
  endtask

  initial begin
    int t;
    int t2;
    int when;
    int edges;

    cfg_cpol = 1'b1;
    tick(3);
    check_output("reset clk", int'(spi_clk_fb), 0);
    check_output("reset busy", int'(busy), 0);
    check_output("reset done", int'(done), 0);
    reset = 1'b0;
    tick(1);
    check_output("idle clk follows cpol", int'(spi_clk_fb), 1);

    // Basic frame; cfg changes and a stray start after the latch must be ignored.
    apply_stimulus(2, 1, 4, 0);
    tick(2);
    fire(t);
    apply_stimulus(5, 3, 9, 0);
    check_output("basic busy@T+1", int'(busy), 1);
    at_cycle(t + 5);
    check_output("basic rise1 clk", int'(spi_clk_fb), 1);
    check_output("basic rise1 lead", int'(lead_edge), 1);
    at_cycle(t + 7);
    check_output("basic fall1 trail", int'(trail_edge), 1);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    at_cycle(t + 18);
    check_output("basic no early done", int'(done), 0);
    at_cycle(t + 19);
    check_output("basic done", int'(done), 1);
    check_output("basic busy at done", int'(busy), 0);
    tick(3);

    // cpol=1, minimal frame
    apply_stimulus(1, 0, 1, 1);
    tick(2);
    fire(t);
    check_output("cpol1 idle-level clk", int'(spi_clk_fb), 1);
    at_cycle(t + 2);
    check_output("cpol1 lead clk", int'(spi_clk_fb), 0);
    check_output("cpol1 lead", int'(lead_edge), 1);
    at_cycle(t + 3);
    check_output("cpol1 trail+done", int'({spi_clk_fb, trail_edge, done}), 7);
    tick(2);

    // Rejected configurations
    apply_stimulus(0, 1, 4, 0);
    tick(2);
    fire(t);
    check_output("reject scale0 err", int'(cfg_err), 1);
    check_output("reject scale0 busy", int'(busy), 0);
    apply_stimulus(2, 1, BMAX + 1, 0);
    fire(t);
    check_output("reject bits err", int'(cfg_err), 1);
    tick(4);

    // Abort in RUN
    apply_stimulus(2, 1, 4, 0);
    fire(t);
    at_cycle(t + 10);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check_output("abort clk", int'(spi_clk_fb), 0);
    check_output("abort busy", int'(busy), 0);
    tick(12);

    // Abort in IDLE is harmless; start+abort together in IDLE starts
    abort = 1'b1;
    tick(1);
    start = 1'b1;
    t = cyc;
    tick(1);
    start = 1'b0;
    abort = 1'b0;
    check_output("start+abort busy", int'(busy), 1);
    wait_done(100, when, edges);
    check_output("start+abort done cycle", when, t + 19);
    tick(2);

    // Abort during DELAY with cpol=1
    apply_stimulus(3, 3, 2, 1);
    tick(2);
    fire(t);
    at_cycle(t + 4);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check_output("delay abort clk", int'(spi_clk_fb), 1);
    check_output("delay abort busy", int'(busy), 0);
    tick(3);

    // Back-to-back frames with start held high
    apply_stimulus(2, 1, 4, 0);
    tick(2);
    start = 1'b1;
    t = cyc;
    at_cycle(t + 19);
    check_output("b2b first done", int'(done), 1);
    tick(1);
    start = 1'b0;
    check_output("b2b busy again", int'(busy), 1);
    at_cycle(t + 24);
    check_output("b2b first rise", int'(lead_edge), 1);
    wait_done(100, when, edges);
    check_output("b2b second done cycle", when, t + 38);
    tick(2);

    // Reset mid-frame, restart on the first cycle after release
    fire(t);
    at_cycle(t + 8);
    reset = 1'b1;
    tick(2);
    check_output("midreset clk", int'(spi_clk_fb), 0);
    check_output("midreset busy", int'(busy), 0);
    reset = 1'b0;
    start = 1'b1;
    t2 = cyc;
    tick(1);
    start = 1'b0;
    check_output("restart busy", int'(busy), 1);
    wait_done(100, when, edges);
    check_output("restart done cycle", when, t2 + 19);
    tick(2);

    // Maximum limits
    apply_stimulus(255, 7, 64, 0);
    tick(1);
    fire(t);
    wait_done(40000, when, edges);
    check_output("max done cycle", when, t + 1 + 255 * 135);
    check_output("max toggle count", edges, 128);
    tick(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
